// File: rtl/gcd_rr_scheduler_if.sv
// Request and response channels of the shared GCD engine.
//
// Valid/ready semantics (all channels):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. A requester keeps its req_a/req_b slice stable while its req_valid
//   bit is high. It may drop req_valid before it is granted, and it is then
//   simply skipped. The engine keeps rsp_gcd/rsp_id/rsp_timeout stable from
//   the rise of rsp_valid until the response transfer. req_ready depends
//   combinationally on req_valid. No engine output depends on rsp_ready.
interface gcd_rr_scheduler_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_gcd;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_timeout;

    // Operand sources and the result consumer.
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_gcd, rsp_id, rsp_timeout
    );

    // The scheduler itself.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_gcd, rsp_id, rsp_timeout
    );
endinterface

// File: rtl/gcd_rr_scheduler.sv
// One iterative Euclid GCD engine shared by NREQ requesters.
// A round-robin arbiter accepts one job in IDLE. COMPUTE then runs one
// modulo step per cycle, up to MAX_ITER steps. RESP holds the tagged result
// until the consumer takes it.
module gcd_rr_scheduler #(
    parameter int WIDTH    = 16,
    parameter int NREQ     = 4,
    parameter int MAX_ITER = 32
) (
    input  logic                clk,
    input  logic                rst,
    gcd_rr_scheduler_if.slave   bus,
    output logic                busy,
    output logic [1:0]          state_dbg
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int ITW = $clog2(MAX_ITER + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   id_r;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic [ITW-1:0]   iter;

    logic             rsp_valid_r;
    logic [WIDTH-1:0] rsp_gcd_r;
    logic [IDW-1:0]   rsp_id_r;
    logic             rsp_timeout_r;

    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   ptr_next;
    logic             accept;
    logic [NREQ-1:0]  req_ready_c;

    logic             x_gt_y;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;

    // Unpack the flat operand buses into per-requester words.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = bus.req_a[i*WIDTH +: WIDTH];
            b_arr[i] = bus.req_b[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin search: first pending requester at or above ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr) + i) % NREQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // The pointer moves to the slot after the winner, so that winner goes last next time.
    assign ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

    // Accept only in IDLE, and never while reset is being applied.
    assign accept = (state == IDLE) && !rst && grant_found;

    // One-hot ready towards the granted requester; zero otherwise.
    always_comb begin
        req_ready_c = '0;
        if (accept) begin
            req_ready_c[grant_idx] = 1'b1;
        end
    end

    // The modulo unit reduces the larger operand by the smaller one.
    // A tie reduces ys, which leaves ys at zero after one step.
    // The zero-divisor guard only matters outside COMPUTE, because the
    // zero check runs before any step is taken.
    assign x_gt_y   = (xs > ys);
    assign dividend = x_gt_y ? xs : ys;
    assign divisor  = x_gt_y ? ys : xs;
    assign rem      = (divisor == '0) ? '0 : (dividend % divisor);

    // Scheduler FSM: arbitration, Euclid iteration and the response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            id_r          <= '0;
            xs            <= '0;
            ys            <= '0;
            iter          <= '0;
            rsp_valid_r   <= 1'b0;
            rsp_gcd_r     <= '0;
            rsp_id_r      <= '0;
            rsp_timeout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        xs    <= a_arr[grant_idx];
                        ys    <= b_arr[grant_idx];
                        id_r  <= grant_idx;
                        iter  <= '0;
                        ptr   <= ptr_next;
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (xs == '0 || ys == '0) begin
                        rsp_gcd_r     <= (xs == '0) ? ys : xs;
                        rsp_timeout_r <= 1'b0;
                        rsp_id_r      <= id_r;
                        rsp_valid_r   <= 1'b1;
                        state         <= RESP;
                    end else if (iter == ITW'(MAX_ITER)) begin
                        rsp_gcd_r     <= xs;
                        rsp_timeout_r <= 1'b1;
                        rsp_id_r      <= id_r;
                        rsp_valid_r   <= 1'b1;
                        state         <= RESP;
                    end else begin
                        if (x_gt_y) begin
                            xs <= rem;
                        end else begin
                            ys <= rem;
                        end
                        iter <= iter + ITW'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_c;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_gcd     = rsp_gcd_r;
    assign bus.rsp_id      = rsp_id_r;
    assign bus.rsp_timeout = rsp_timeout_r;
    assign busy            = (state != IDLE);
    assign state_dbg       = state;
endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Bench for gcd_rr_scheduler. It has two instances: the default one, and one
// with MAX_ITER=2 for the timeout cases. Expected results come from a plain
// Euclid reference model and a round-robin pointer model.
module tb_gcd_rr_scheduler;
    localparam int WIDTH      = 16;
    localparam int NREQ       = 4;
    localparam int MAX_ITER   = 32;
    localparam int SHORT_ITER = 2;
    localparam int IDW        = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    bit   sel = 1'b0;

    // Scoreboard entries are packed as {id, timeout, gcd}.
    logic [IDW+WIDTH:0] exp_q[$];

    gcd_rr_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();
    gcd_rr_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus_s ();
    logic       busy, busy_s;
    logic [1:0] state_dbg, state_dbg_s;

    gcd_rr_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .state_dbg(state_dbg));
    gcd_rr_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_ITER(SHORT_ITER)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s), .busy(busy_s), .state_dbg(state_dbg_s));

    // View of whichever instance the current job targets.
    wire [NREQ-1:0]  s_req_ready   = sel ? bus_s.req_ready   : bus.req_ready;
    wire             s_rsp_valid   = sel ? bus_s.rsp_valid   : bus.rsp_valid;
    wire [WIDTH-1:0] s_rsp_gcd     = sel ? bus_s.rsp_gcd     : bus.rsp_gcd;
    wire [IDW-1:0]   s_rsp_id      = sel ? bus_s.rsp_id      : bus.rsp_id;
    wire             s_rsp_timeout = sel ? bus_s.rsp_timeout : bus.rsp_timeout;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Repeatedly replace the larger value by larger mod smaller. A zero operand
    // ends the job. After maxit steps the job ends with x and the timeout flag.
    function automatic void ref_gcd(input int unsigned a, input int unsigned b,
                                    input int unsigned maxit, output int unsigned g,
                                    output bit to, output int unsigned steps);
        int unsigned x, y;
        x = a; y = b; g = 0; to = 1'b0; steps = 0;
        for (int unsigned s = 0; s <= maxit; s++) begin
            if (x == 0 || y == 0) begin
                g = (x == 0) ? y : x; steps = s; return;
            end
            if (s == maxit) begin
                g = x; to = 1'b1; steps = s; return;
            end
            if (x > y) x = x % y; else y = y % x;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.req_valid = '0;   bus.req_a = '0;   bus.req_b = '0;   bus.rsp_ready = 1'b1;
        bus_s.req_valid = '0; bus_s.req_a = '0; bus_s.req_b = '0; bus_s.rsp_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_req(input bit s, input int id, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
        if (s) begin
            bus_s.req_a[id*WIDTH +: WIDTH] = a;
            bus_s.req_b[id*WIDTH +: WIDTH] = b;
            bus_s.req_valid[id] = 1'b1;
        end else begin
            bus.req_a[id*WIDTH +: WIDTH] = a;
            bus.req_b[id*WIDTH +: WIDTH] = b;
            bus.req_valid[id] = 1'b1;
        end
    endtask

    task automatic clr_req(input bit s, input int id);
        if (s) bus_s.req_valid[id] = 1'b0;
        else   bus.req_valid[id] = 1'b0;
    endtask

    // Presents one job, waits (bounded) for its handshake and its response,
    // and reports the cycle numbers and response fields. -1 means never seen.
    task automatic run_job(input bit s, input int id, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, output int t_hs, output int t_rsp,
                           output logic [WIDTH-1:0] g, output logic [IDW-1:0] rid,
                           output logic to);
        t_hs = -1; t_rsp = -1; g = '0; rid = '0; to = 1'b0;
        sel = s;
        set_req(s, id, a, b);
        #1;
        for (int i = 0; i < 50 && t_hs < 0; i++) begin
            if (s_req_ready[id]) t_hs = cyc;
            else @(negedge clk);
        end
        if (t_hs < 0) begin
            clr_req(s, id);
            return;
        end
        @(negedge clk);
        clr_req(s, id);
        for (int i = 0; i < 200 && t_rsp < 0; i++) begin
            if (s_rsp_valid) begin
                t_rsp = cyc; g = s_rsp_gcd; rid = s_rsp_id; to = s_rsp_timeout;
            end else begin
                @(negedge clk);
            end
        end
        if (t_rsp >= 0) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        bus.req_valid = '1;
        #1;
        tests_run++; if (bus.req_ready !== '0) begin tests_failed++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        tests_run++; if (bus.rsp_gcd !== '0) begin tests_failed++; $display("FAIL reset_rsp_gcd: got %0d expected 0", bus.rsp_gcd); end
        tests_run++; if (bus.rsp_id !== '0 || bus.rsp_timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_id_to: got id=%0d to=%b expected 0/0", bus.rsp_id, bus.rsp_timeout); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        int t_hs, t_rsp; logic [WIDTH-1:0] g; logic [IDW-1:0] rid; logic to;
        run_job(1'b0, 2, 16'd48, 16'd18, t_hs, t_rsp, g, rid, to);
        tests_run++; if (t_hs < 0 || t_rsp != t_hs + 5) begin tests_failed++; $display("FAIL single_r2_latency: got hs=%0d rsp=%0d expected rsp=hs+5", t_hs, t_rsp); end
        tests_run++; if (g !== 16'd6 || rid !== 2'd2 || to !== 1'b0) begin tests_failed++; $display("FAIL single_r2_result: got gcd=%0d id=%0d to=%b expected 6/2/0", g, rid, to); end
        run_job(1'b0, 0, 16'd12, 16'd18, t_hs, t_rsp, g, rid, to);
        tests_run++; if (t_hs < 0 || t_rsp != t_hs + 4) begin tests_failed++; $display("FAIL single_r0_latency: got hs=%0d rsp=%0d expected rsp=hs+4", t_hs, t_rsp); end
        tests_run++; if (g !== 16'd6 || rid !== 2'd0 || to !== 1'b0) begin tests_failed++; $display("FAIL single_r0_result: got gcd=%0d id=%0d to=%b expected 6/0/0", g, rid, to); end
    endtask

    task automatic test_degenerate();
        int da[4] = '{0, 7, 0, 9};
        int db[4] = '{5, 0, 0, 9};
        int dg[4] = '{5, 7, 0, 9};
        int dl[4] = '{2, 2, 2, 3};
        int t_hs, t_rsp; logic [WIDTH-1:0] g; logic [IDW-1:0] rid; logic to;
        for (int i = 0; i < 4; i++) begin
            run_job(1'b0, (i + 1) % NREQ, WIDTH'(da[i]), WIDTH'(db[i]), t_hs, t_rsp, g, rid, to);
            tests_run++;
            if (t_hs < 0 || t_rsp != t_hs + dl[i] || g !== WIDTH'(dg[i]) || rid !== IDW'((i + 1) % NREQ) || to !== 1'b0) begin
                tests_failed++;
                $display("FAIL degenerate_%0d_%0d: got lat=%0d gcd=%0d id=%0d to=%b expected lat=%0d gcd=%0d id=%0d to=0",
                         da[i], db[i], t_rsp - t_hs, g, rid, to, dl[i], dg[i], (i + 1) % NREQ);
            end
        end
    endtask

    task automatic test_random();
        int t_hs, t_rsp; logic [WIDTH-1:0] g; logic [IDW-1:0] rid; logic to;
        int id; logic [WIDTH-1:0] a, b; int unsigned eg, est; bit eto;
        for (int n = 0; n < 16; n++) begin
            id = $urandom_range(0, NREQ - 1);
            a = ($urandom_range(0, 4) == 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom_range(1, 65535));
            b = ($urandom_range(0, 4) == 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom_range(1, 65535));
            ref_gcd(a, b, MAX_ITER, eg, eto, est);
            run_job(1'b0, id, a, b, t_hs, t_rsp, g, rid, to);
            tests_run++;
            if (t_hs < 0 || t_rsp != t_hs + int'(est) + 2 || g !== WIDTH'(eg) || rid !== IDW'(id) || to !== eto) begin
                tests_failed++;
                $display("FAIL random_job(%0d,%0d): got lat=%0d gcd=%0d id=%0d to=%b expected lat=%0d gcd=%0d id=%0d to=%b",
                         a, b, t_rsp - t_hs, g, rid, to, est + 2, eg, id, eto);
            end
        end
    endtask

    task automatic test_timeout();
        int t_hs, t_rsp; logic [WIDTH-1:0] g; logic [IDW-1:0] rid; logic to;
        logic [WIDTH-1:0] a, b; int unsigned eg, est; bit eto;
        run_job(1'b1, 1, 16'd48, 16'd18, t_hs, t_rsp, g, rid, to);
        tests_run++; if (t_hs < 0 || t_rsp != t_hs + 4 || g !== 16'd12 || to !== 1'b1 || rid !== 2'd1) begin tests_failed++; $display("FAIL timeout_48_18: got lat=%0d gcd=%0d to=%b id=%0d expected lat=4 gcd=12 to=1 id=1", t_rsp - t_hs, g, to, rid); end
        run_job(1'b1, 3, 16'd12, 16'd18, t_hs, t_rsp, g, rid, to);
        tests_run++; if (t_hs < 0 || t_rsp != t_hs + 4 || g !== 16'd6 || to !== 1'b0) begin tests_failed++; $display("FAIL timeout_edge_12_18: got lat=%0d gcd=%0d to=%b expected lat=4 gcd=6 to=0", t_rsp - t_hs, g, to); end
        for (int n = 0; n < 4; n++) begin
            a = WIDTH'($urandom_range(1, 65535)); b = WIDTH'($urandom_range(1, 65535));
            ref_gcd(a, b, SHORT_ITER, eg, eto, est);
            run_job(1'b1, n, a, b, t_hs, t_rsp, g, rid, to);
            tests_run++;
            if (t_hs < 0 || t_rsp != t_hs + int'(est) + 2 || g !== WIDTH'(eg) || to !== eto) begin
                tests_failed++;
                $display("FAIL timeout_random(%0d,%0d): got lat=%0d gcd=%0d to=%b expected lat=%0d gcd=%0d to=%b", a, b, t_rsp - t_hs, g, to, est + 2, eg, eto);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [WIDTH-1:0] av[NREQ], bv[NREQ];
        logic [NREQ-1:0] prev_ready;
        logic [IDW+WIDTH:0] e;
        int rr_next, grants, resps, gi, want;
        int unsigned g, st; bit to;
        exp_q.delete();
        do_reset();
        sel = 1'b0; rr_next = 0; grants = 0; resps = 0; prev_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            av[i] = WIDTH'($urandom_range(1, 65535));
            bv[i] = WIDTH'($urandom_range(1, 65535));
            set_req(1'b0, i, av[i], bv[i]);
        end
        #1;
        for (int c = 0; c < 600 && resps < 5; c++) begin
            if (bus.req_ready != '0) begin
                gi = -1; want = -1;
                for (int k = 0; k < NREQ; k++) if (bus.req_ready[k]) gi = k;
                for (int k = 0; k < NREQ && want < 0; k++) if (bus.req_valid[(rr_next + k) % NREQ]) want = (rr_next + k) % NREQ;
                tests_run++;
                if (!$onehot(bus.req_ready) || busy !== 1'b0 || prev_ready !== '0 || gi != want) begin
                    tests_failed++;
                    $display("FAIL rr_grant_%0d: got ready=%b busy=%b prev=%b expected grant %0d one cycle in IDLE", grants, bus.req_ready, busy, prev_ready, want);
                end
                rr_next = (want + 1) % NREQ;
                ref_gcd(av[want], bv[want], MAX_ITER, g, to, st);
                exp_q.push_back({IDW'(want), to, WIDTH'(g)});
                grants++;
            end
            if (bus.rsp_valid) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++; $display("FAIL rr_rsp_%0d: got unexpected response expected none", resps);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.rsp_id, bus.rsp_timeout, bus.rsp_gcd} !== e) begin
                        tests_failed++;
                        $display("FAIL rr_rsp_%0d: got id=%0d to=%b gcd=%0d expected id=%0d to=%b gcd=%0d", resps,
                                 bus.rsp_id, bus.rsp_timeout, bus.rsp_gcd, e[IDW+WIDTH:WIDTH+1], e[WIDTH], e[WIDTH-1:0]);
                    end
                end
                resps++;
                if (resps == 5) bus.req_valid = '0;
            end
            prev_ready = bus.req_ready;
            @(negedge clk); #1;
        end
        tests_run++; if (grants != 5 || resps != 5) begin tests_failed++; $display("FAIL rr_budget: got grants=%0d resps=%0d expected 5/5", grants, resps); end
    endtask

    task automatic test_back_pressure();
        logic [WIDTH-1:0] a1, b1, a3, b3, sg; logic [IDW-1:0] sid; logic sto;
        int unsigned g, st; bit to; int t_hs, t_rsp;
        exp_q.delete();
        sel = 1'b0;
        a1 = WIDTH'($urandom_range(1, 65535)); b1 = WIDTH'($urandom_range(1, 65535));
        a3 = WIDTH'($urandom_range(1, 65535)); b3 = WIDTH'($urandom_range(1, 65535));
        bus.rsp_ready = 1'b0;
        set_req(1'b0, 1, a1, b1);
        #1;
        t_hs = -1;
        for (int i = 0; i < 50 && t_hs < 0; i++) begin
            if (bus.req_ready[1]) t_hs = cyc; else @(negedge clk);
        end
        @(negedge clk);
        clr_req(1'b0, 1);
        set_req(1'b0, 3, a3, b3);
        t_rsp = -1;
        for (int i = 0; i < 200 && t_rsp < 0; i++) begin
            if (bus.rsp_valid) t_rsp = cyc; else @(negedge clk);
        end
        ref_gcd(a1, b1, MAX_ITER, g, to, st);
        sg = bus.rsp_gcd; sid = bus.rsp_id; sto = bus.rsp_timeout;
        tests_run++;
        if (t_hs < 0 || t_rsp < 0 || sg !== WIDTH'(g) || sid !== 2'd1 || sto !== to) begin
            tests_failed++;
            $display("FAIL bp_result: got hs=%0d rsp=%0d gcd=%0d id=%0d to=%b expected gcd=%0d id=1 to=%b", t_hs, t_rsp, sg, sid, sto, g, to);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_gcd !== sg || bus.rsp_id !== sid || bus.rsp_timeout !== sto || bus.req_ready !== '0) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d: got valid=%b gcd=%0d id=%0d to=%b ready=%b expected 1/%0d/%0d/%b/0000",
                         i, bus.rsp_valid, bus.rsp_gcd, bus.rsp_id, bus.rsp_timeout, bus.req_ready, sg, sid, sto);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        tests_run++; if (bus.req_ready !== 4'b1000) begin tests_failed++; $display("FAIL bp_next_grant: got ready=%b expected 1000", bus.req_ready); end
        ref_gcd(a3, b3, MAX_ITER, g, to, st);
        @(negedge clk);
        clr_req(1'b0, 3);
        t_rsp = -1;
        for (int i = 0; i < 200 && t_rsp < 0; i++) begin
            if (bus.rsp_valid) t_rsp = cyc; else @(negedge clk);
        end
        tests_run++;
        if (t_rsp < 0 || bus.rsp_gcd !== WIDTH'(g) || bus.rsp_id !== 2'd3 || bus.rsp_timeout !== to) begin
            tests_failed++;
            $display("FAIL bp_second_job: got rsp=%0d gcd=%0d id=%0d expected gcd=%0d id=3", t_rsp, bus.rsp_gcd, bus.rsp_id, g);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int t_hs, t_rsp; bit seen; int unsigned g, st; bit to;
        sel = 1'b0;
        set_req(1'b0, 1, 16'd48, 16'd18);
        #1;
        t_hs = -1;
        for (int i = 0; i < 50 && t_hs < 0; i++) begin
            if (bus.req_ready[1]) t_hs = cyc; else @(negedge clk);
        end
        @(negedge clk);
        clr_req(1'b0, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (t_hs < 0 || bus.rsp_valid !== 1'b0 || bus.rsp_gcd !== '0 || bus.rsp_id !== '0 || bus.rsp_timeout !== 1'b0 || busy !== 1'b0 || bus.req_ready !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got valid=%b gcd=%0d id=%0d to=%b busy=%b ready=%b expected all zero",
                     bus.rsp_valid, bus.rsp_gcd, bus.rsp_id, bus.rsp_timeout, busy, bus.req_ready);
        end
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        tests_run++; if (seen) begin tests_failed++; $display("FAIL mid_reset_no_rsp: got response after reset expected none"); end
        set_req(1'b0, 3, 16'd35, 16'd21);
        set_req(1'b0, 0, 16'd40, 16'd24);
        #1;
        tests_run++; if (bus.req_ready !== 4'b0001) begin tests_failed++; $display("FAIL mid_reset_ptr: got ready=%b expected 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        ref_gcd(40, 24, MAX_ITER, g, to, st);
        t_rsp = -1;
        for (int i = 0; i < 200 && t_rsp < 0; i++) begin
            if (bus.rsp_valid) t_rsp = cyc; else @(negedge clk);
        end
        tests_run++;
        if (t_rsp < 0 || bus.rsp_id !== 2'd0 || bus.rsp_gcd !== WIDTH'(g)) begin
            tests_failed++;
            $display("FAIL mid_reset_job: got rsp=%0d id=%0d gcd=%0d expected id=0 gcd=%0d", t_rsp, bus.rsp_id, bus.rsp_gcd, g);
        end
        @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        drive_idle();
        test_reset();
        test_single();
        test_degenerate();
        test_random();
        test_timeout();
        test_round_robin();
        test_back_pressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
